// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register-file writeback arbiter
package regfile_pkg;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int NREG      = 32;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback, issue and register-file port bundle (optional WB_BYPASS_EN)
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic     alu_valid;
    reg_idx_t alu_rd;
    data_t    alu_data;
    logic     alu_ready;
    logic     ld_valid;
    reg_idx_t ld_rd;
    data_t    ld_data;
    logic     ld_ready;
    logic     issue_valid;
    reg_idx_t issue_rd;
    logic     issue_ready;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     rs1_busy;
    logic     rs2_busy;
    reg_idx_t w_reg;
    data_t    w_data;
    logic     Reg_Write;
    logic     sb_err;
`ifdef WB_BYPASS_EN
    logic     rs1_fwd;
    logic     rs2_fwd;
    data_t    fwd_data;
`endif

    modport slave (
`ifdef WB_BYPASS_EN
        output rs1_fwd, rs2_fwd, fwd_data,
`endif
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  issue_valid, issue_rd, rs1, rs2,
        output alu_ready, ld_ready, issue_ready, rs1_busy, rs2_busy,
        output w_reg, w_data, Reg_Write, sb_err
    );

    modport master (
`ifdef WB_BYPASS_EN
        input  rs1_fwd, rs2_fwd, fwd_data,
`endif
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output issue_valid, issue_rd, rs1, rs2,
        input  alu_ready, ld_ready, issue_ready, rs1_busy, rs2_busy,
        input  w_reg, w_data, Reg_Write, sb_err
    );
endinterface

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register pending-write counters, issue stall, busy query (optional WB_BYPASS_EN)
module wb_scoreboard #(
    parameter int PEND_W = 2,
    parameter int NREG   = regfile_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  regfile_pkg::reg_idx_t issue_rd,
    input  regfile_pkg::reg_idx_t rs1,
    input  regfile_pkg::reg_idx_t rs2,
    input  logic                 commit_we,
    input  regfile_pkg::reg_idx_t commit_reg,
    output logic                 issue_ready,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
`ifdef WB_BYPASS_EN
    output logic                 rs1_fwd,
    output logic                 rs2_fwd,
`endif
    output logic                 sb_err
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt_q [NREG];
    logic [PEND_W-1:0] cnt_d [NREG];
    logic              sb_err_q;
    logic              sb_err_d;
    logic              inc;
    logic              dec;

    // A commit in the same cycle frees a slot, so a full counter may still accept.
    always_comb begin
        issue_ready = 1'b1;
        if (issue_rd != '0 && cnt_q[issue_rd] == CNT_MAX &&
            !(commit_we && commit_reg == issue_rd))
            issue_ready = 1'b0;
    end

    always_comb begin
        sb_err_d = sb_err_q;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            inc = issue_valid && issue_ready && issue_rd != '0 && int'(issue_rd) == r;
            dec = commit_we && int'(commit_reg) == r;
            if (dec && cnt_q[r] == '0)
                sb_err_d = 1'b1;
            else if (dec && !inc)
                cnt_d[r] = cnt_q[r] - 1'b1;
            else if (inc && !dec)
                cnt_d[r] = cnt_q[r] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

`ifdef WB_BYPASS_EN
    localparam logic [PEND_W-1:0] CNT_ONE = 1;

    // The last outstanding write retiring now can be forwarded straight to decode.
    always_comb begin
        rs1_fwd  = commit_we && commit_reg == rs1 && cnt_q[rs1] == CNT_ONE;
        rs2_fwd  = commit_we && commit_reg == rs2 && cnt_q[rs2] == CNT_ONE;
        rs1_busy = rs1 != '0 && cnt_q[rs1] != '0 && !rs1_fwd;
        rs2_busy = rs2 != '0 && cnt_q[rs2] != '0 && !rs2_fwd;
    end
`else
    always_comb begin
        rs1_busy = rs1 != '0 && cnt_q[rs1] != '0;
        rs2_busy = rs2 != '0 && cnt_q[rs2] != '0;
    end
`endif

    assign sb_err = sb_err_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter feeding the register file port (optional WB_BYPASS_EN)
module regfile_wb_arbiter #(
    parameter int PEND_W = 2,
    parameter int NREG   = regfile_pkg::NREG
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    import regfile_pkg::*;

    logic     rr_ptr_q;
    logic     rr_ptr_d;
    reg_idx_t w_reg_q;
    reg_idx_t w_reg_d;
    data_t    w_data_q;
    data_t    w_data_d;
    logic     reg_write_q;
    logic     reg_write_d;

    // rr_ptr only matters when both requesters are valid.
    assign bus.alu_ready = bus.alu_valid && (!bus.ld_valid || rr_ptr_q == REQ_ALU);
    assign bus.ld_ready  = bus.ld_valid  && (!bus.alu_valid || rr_ptr_q == REQ_LD);

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        w_reg_d     = w_reg_q;
        w_data_d    = w_data_q;
        reg_write_d = 1'b0;
        if (bus.alu_ready) begin
            w_reg_d     = bus.alu_rd;
            w_data_d    = bus.alu_data;
            reg_write_d = bus.alu_rd != '0;
            rr_ptr_d    = REQ_LD;
        end else if (bus.ld_ready) begin
            w_reg_d     = bus.ld_rd;
            w_data_d    = bus.ld_data;
            reg_write_d = bus.ld_rd != '0;
            rr_ptr_d    = REQ_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= REQ_ALU;
            w_reg_q     <= '0;
            w_data_q    <= '0;
            reg_write_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            w_reg_q     <= w_reg_d;
            w_data_q    <= w_data_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign bus.w_reg     = w_reg_q;
    assign bus.w_data    = w_data_q;
    assign bus.Reg_Write = reg_write_q;
`ifdef WB_BYPASS_EN
    assign bus.fwd_data  = w_data_q;
`endif

    wb_scoreboard #(
        .PEND_W (PEND_W),
        .NREG   (NREG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .rs1         (bus.rs1),
        .rs2         (bus.rs2),
        .commit_we   (reg_write_q),
        .commit_reg  (w_reg_q),
        .issue_ready (bus.issue_ready),
        .rs1_busy    (bus.rs1_busy),
        .rs2_busy    (bus.rs2_busy),
`ifdef WB_BYPASS_EN
        .rs1_fwd     (bus.rs1_fwd),
        .rs2_fwd     (bus.rs2_fwd),
`endif
        .sb_err      (bus.sb_err)
    );
endmodule
